// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default parameters for the FIFO flow-control slice.
// Optional error flags are enabled with FIFO_FLOW_ERR_EN.
package fifo_pkg;

    localparam int DEF_ADDR       = 4;
    localparam int DEF_RD_LATENCY = 2;
    localparam int DEF_AF_THRESH  = 12;
    localparam int DEF_AE_THRESH  = 2;

    function automatic int fifo_depth(input int addr);
        return 1 << addr;
    endfunction

    function automatic int cnt_w(input int addr);
        return addr + 1;
    endfunction

endpackage

// File: rtl/fifo_flow_ctrl_rd_valid_pipe.sv
// Fixed-latency shift register that turns an accepted rd strobe into rd_valid.
// Optional error flags elsewhere are enabled with FIFO_FLOW_ERR_EN.
module rd_valid_pipe #(
    parameter int RD_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rd,
    output logic rd_valid
);

    logic [RD_LATENCY-1:0] sr_q;
    logic [RD_LATENCY-1:0] sr_d;
    logic [RD_LATENCY:0]   ext;

    always_comb begin
        ext  = {sr_q, rd};
        sr_d = ext[RD_LATENCY-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= sr_d;
    end

    assign rd_valid = sr_q[RD_LATENCY-1];

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Occupancy tracking and gated wr/rd strobes for the FIFO address counter.
// Define FIFO_FLOW_ERR_EN to add sticky ovf_err/udf_err outputs.
module fifo_flow_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR       = DEF_ADDR,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int AF_THRESH  = DEF_AF_THRESH,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    output logic          push_ready,
    input  logic          pop,
    output logic          pop_ready,
    output logic          wr,
    output logic          rd,
    output logic          rd_valid,
    output logic [ADDR:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty
`ifdef FIFO_FLOW_ERR_EN
    ,
    output logic          ovf_err,
    output logic          udf_err
`endif
);

    localparam int CW    = cnt_w(ADDR);
    localparam int DEPTH = fifo_depth(ADDR);
    // Out-of-range thresholds saturate so the flag is stuck off/on.
    localparam logic [CW-1:0] AF_T =
        CW'((AF_THRESH > DEPTH) ? DEPTH + 1 : AF_THRESH);
    localparam logic [CW-1:0] AE_T =
        CW'((AE_THRESH > DEPTH) ? DEPTH : AE_THRESH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_T);
    assign almost_empty = (count_q <= AE_T);
    assign push_ready   = ~full;
    assign pop_ready    = ~empty;
    assign wr           = push & ~full;
    assign rd           = pop & ~empty;
    assign count        = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    rd_valid_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd),
        .rd_valid (rd_valid)
    );

`ifdef FIFO_FLOW_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (push & full);
        udf_d = udf_q | (pop & empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule

// File: doc/fifo_flow_ctrl.md
Name: fifo_flow_ctrl

Overview:
- Upstream control stage for the FIFO address counter (fifo_logic).
- Accepts push/pop requests from the producer and consumer sides and tracks occupancy.
- Generates the gated wr/rd strobes that advance the write/read addresses into SDRAM.
- Raises rd_valid a fixed latency after each accepted pop, matching the memory read path.

Parameters:
- ADDR, 4: address width; must equal the fifo_logic ADDR; DEPTH = 2**ADDR entries.
- RD_LATENCY, 2: cycles from accepted pop (rd strobe) to data valid at the memory output; legal range 1..8.
- AF_THRESH, 12: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset); synchronous release handled at top level.
- push  input  1  producer requests a write this cycle.
- push_ready  output  1  = ~full; a push is accepted only when push & push_ready.
- pop  input  1  consumer requests a read this cycle.
- pop_ready  output  1  = ~empty; a pop is accepted only when pop & pop_ready.
- wr  output  1  accepted-write strobe to the address counter (combinational: push & ~full).
- rd  output  1  accepted-read strobe to the address counter (combinational: pop & ~empty).
- rd_valid  output  1  data from an accepted pop is valid at the memory output.
- count  output  ADDR+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.

Behaviour:
- Reset (rst=0, any time, asynchronous): count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid pipeline cleared. push_ready=1, pop_ready=0.
- Reset mid-operation: in-flight rd_valid pulses are discarded. The top level resets fifo_logic from the same source, so pointers and count realign.
- Flags (full, empty, almost_*) decode only registered count, so they never depend on same-cycle requests.
- Occupancy update on each posedge:
  - wr only: count+1.
  - rd only: count-1.
  - both or neither: count unchanged.
- Simultaneous push and pop:
  - When full: push is refused even if a pop is accepted; count goes DEPTH -> DEPTH-1.
  - When empty: pop is refused; the push is accepted; count goes 0 -> 1.
- Wrap-around: count never exceeds DEPTH and never underflows; address wrap is handled in fifo_logic.
- Read latency:
  - rd enters a RD_LATENCY-deep shift register; rd_valid is its tail.
  - A pop accepted in cycle N gives rd_valid high in cycle N+RD_LATENCY.
  - Back-to-back pops produce back-to-back rd_valid; no bubbles are inserted.
- Thresholds are compared as unsigned ADDR+1-bit values. AF_THRESH > DEPTH means almost_full never asserts.

Optional Feature:
- Macro: FIFO_FLOW_ERR_EN.
- With the macro, add two outputs:
  - ovf_err (1): sticky; set on the cycle after push & full.
  - udf_err (1): sticky; set on the cycle after pop & empty.
  - Both clear only on reset (reset value 0).
- Without the macro, the ports do not exist. Refused requests are silently dropped; push_ready and pop_ready are the only indication.

Decomposition:
- Package fifo_pkg holds:
  - DEPTH derivation from ADDR.
  - Count width function (ADDR+1).
  - Default RD_LATENCY and threshold constants, shared with fifo_logic instantiation at top.
- One sub-module, rd_valid_pipe: parameterised RD_LATENCY shift register with async active-low reset; input rd, output rd_valid.

Test Plan (ADDR=4, DEPTH=16, RD_LATENCY=2, AF=12, AE=2):
- Reset, then 16 pushes -> wr pulses 16 times; count reaches 16; full=1, push_ready=0; almost_full asserts after the 12th push.
- Push while full, with pop=0 -> wr=0, count stays 16. With FIFO_FLOW_ERR_EN: ovf_err=1 next cycle and remains 1.
- Pop at full for 3 back-to-back cycles -> rd in cycles N..N+2; rd_valid in N+2..N+4; count 16 -> 13; full drops after the first pop.
- Simultaneous push and pop at count=5 -> wr=1, rd=1, count stays 5. Same stimulus at count=0 -> wr=1, rd=0, count=1, no rd_valid.
- Pop when empty after reset -> rd=0, rd_valid stays 0, count stays 0. With FIFO_FLOW_ERR_EN: udf_err=1.
- Assert rst=0 asynchronously one cycle after a pop -> rd_valid never pulses; count=0 and empty=1 immediately, without waiting for a clock edge.
